// File: rtl/frame_align_ctrl_pkg.sv
// frame_align_ctrl_pkg: FSM state encoding and default frame pattern for the frame aligner
package frame_align_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_CHECK, S_SLIP, S_LOCKED, S_FAIL} state_t;
  localparam logic [7:0] DEF_FRAME_PATTERN = 8'h0F;
endpackage

// File: rtl/frame_align_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/frame_align_ctrl.sv
// frame_align_ctrl: bitslip sequencer that aligns the ISERDES frame lane and qualifies/monitors lock
module frame_align_ctrl import frame_align_ctrl_pkg::*; #(
  parameter int            DW            = 8,
  parameter logic [DW-1:0] FRAME_PATTERN = DW'(DEF_FRAME_PATTERN),
  parameter int            SETTLE_CYCLES = 16,
  parameter int            MATCH_COUNT   = 32,
  parameter int            ERR_LIMIT     = 4
) (
  input  logic          sample_clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          realign,
  input  logic [DW-1:0] clk_data_in,
  output logic          bitslip,
  output logic          locked,
  output logic          fail,
  output logic [3:0]    slip_cnt,
  output logic [15:0]   frame_err_cnt
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);
  localparam int TW = $clog2(DW + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_COUNT - 1);
  localparam logic [EW-1:0] ERR_LAST    = EW'(ERR_LIMIT - 1);
  localparam logic [TW-1:0] TRY_LAST    = TW'(DW - 1);

  state_t        state, state_n;
  logic [DW-1:0] data_q;
  logic [SW-1:0] settle_cnt, settle_n;
  logic [MW-1:0] match_cnt, match_n;
  logic [EW-1:0] consec, consec_n;
  logic [TW-1:0] tries, tries_n;
  logic [3:0]    slip_n;
  logic          locked_n, fail_n, err_inc, match;

  assign match = data_q == FRAME_PATTERN;

  always_comb begin
    state_n  = state;
    settle_n = '0;
    match_n  = '0;
    consec_n = '0;
    tries_n  = tries;
    slip_n   = slip_cnt;
    locked_n = locked;
    fail_n   = fail;
    err_inc  = 1'b0;
    if (!enable) begin
      state_n  = S_IDLE;
      locked_n = 1'b0;
      fail_n   = 1'b0;
    end else if (realign && state != S_IDLE) begin
      state_n  = S_SETTLE;
      locked_n = 1'b0;
      fail_n   = 1'b0;
      slip_n   = '0;
      tries_n  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_n = S_SETTLE;
          slip_n  = '0;
          tries_n = '0;
        end
        S_SETTLE: begin
          settle_n = settle_cnt == SETTLE_LAST ? '0 : settle_cnt + 1'b1;
          state_n  = settle_cnt == SETTLE_LAST ? S_CHECK : S_SETTLE;
        end
        S_CHECK:
          if (match) begin
            match_n = match_cnt == MATCH_LAST ? '0 : match_cnt + 1'b1;
            if (match_cnt == MATCH_LAST) begin
              state_n  = S_LOCKED;
              locked_n = 1'b1;
            end
          end else if (tries < TRY_LAST) state_n = S_SLIP;
          else begin
            state_n = S_FAIL;
            fail_n  = 1'b1;
          end
        S_SLIP: begin
          state_n = S_SETTLE;
          slip_n  = slip_cnt + 1'b1;
          tries_n = tries + 1'b1;
        end
        S_LOCKED:
          if (!match) begin
            err_inc  = 1'b1;
            consec_n = consec == ERR_LAST ? '0 : consec + 1'b1;
            if (consec == ERR_LAST) begin
              state_n  = S_CHECK;
              locked_n = 1'b0;
              tries_n  = '0;
            end
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sample_clk)
    if (reset) begin
      state      <= S_IDLE;
      data_q     <= '0;
      settle_cnt <= '0;
      match_cnt  <= '0;
      consec     <= '0;
      tries      <= '0;
      slip_cnt   <= '0;
      locked     <= 1'b0;
      fail       <= 1'b0;
      bitslip    <= 1'b0;
    end else begin
      state      <= state_n;
      data_q     <= clk_data_in;
      settle_cnt <= settle_n;
      match_cnt  <= match_n;
      consec     <= consec_n;
      tries      <= tries_n;
      slip_cnt   <= slip_n;
      locked     <= locked_n;
      fail       <= fail_n;
      bitslip    <= state_n == S_SLIP;
    end

  sat_counter #(.W(16)) u_err_cnt (
    .clk(sample_clk),
    .rst(reset),
    .inc(err_inc),
    .clr(1'b0),
    .cnt(frame_err_cnt)
  );
endmodule

// File: tb/tb_frame_align_ctrl.sv
// tb_frame_align_ctrl: directed scenarios against a rotating-frame ISERDES model
module tb_frame_align_ctrl;
  import frame_align_ctrl_pkg::*;

  logic        sample_clk = 1'b0;
  logic        reset = 1'b1, enable = 1'b0, realign = 1'b0;
  logic [7:0]  clk_data_in = 8'h0F;
  logic        bitslip, locked, fail;
  logic [3:0]  slip_cnt;
  logic [15:0] frame_err_cnt;

  int checks = 0, errors = 0;
  int offset = 0, slips = 0, pulses = 0, cyc = 0, last_pulse = -1, min_gap = 1000;
  logic prev_bs = 1'b0, bad_en = 1'b0;
  logic [7:0] bad_word = 8'h00;

  frame_align_ctrl dut (
    .sample_clk(sample_clk), .reset(reset), .enable(enable), .realign(realign),
    .clk_data_in(clk_data_in), .bitslip(bitslip), .locked(locked), .fail(fail),
    .slip_cnt(slip_cnt), .frame_err_cnt(frame_err_cnt)
  );

  always #5 sample_clk = ~sample_clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, time=%0t required < 2ms", $time);
    $fatal(1);
  end

  function automatic logic [7:0] rotl(input logic [7:0] w, input int n);
    logic [15:0] t;
    t = {w, w} << n;
    return t[15:8];
  endfunction

  task automatic drive();
    clk_data_in = bad_en ? bad_word : rotl(8'h0F, ((offset + slips) % 8 + 8) % 8);
  endtask

  // ISERDES model: a pulse seen in one cycle rotates the word after the following edge
  task automatic tick();
    @(posedge sample_clk);
    #1;
    if (prev_bs) slips++;
    prev_bs = bitslip;
    cyc++;
    if (bitslip) begin
      pulses++;
      if (last_pulse >= 0 && cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
      last_pulse = cyc;
    end
    drive();
  endtask

  task automatic set_rotation(input int r);
    offset = r - slips;
    drive();
  endtask

  task automatic wait_lock(input int budget, input string name);
    int n = 0;
    while (!locked && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL %s: locked=%b after %0d cycles, required 1", name, locked, n);
    end
  endtask

  task automatic restart(input int r);
    enable = 1'b0;
    tick();
    set_rotation(r);
    enable = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({bitslip, locked, fail, slip_cnt, frame_err_cnt} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs: got bs=%b lk=%b f=%b slip=%0d err=%0d, required all 0",
               bitslip, locked, fail, slip_cnt, frame_err_cnt);
    end
    checks++;
    if (dut.state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d required %0d", dut.state, S_IDLE);
    end
  endtask

  task automatic test_aligned();
    int p0;
    set_rotation(0);
    p0 = pulses;
    enable = 1'b1;
    repeat (48) tick();
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL aligned_early: locked=%b at cycle 48, required 0", locked);
    end
    tick();
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL aligned_lock: locked=%b at cycle 49, required 1", locked);
    end
    checks++;
    if (pulses - p0 !== 0 || slip_cnt !== 4'd0) begin
      errors++;
      $display("FAIL aligned_slips: pulses=%0d slip_cnt=%0d, required 0 and 0", pulses - p0, slip_cnt);
    end
  endtask

  task automatic test_offset3();
    int p0;
    restart(3);
    p0 = pulses;
    last_pulse = -1;
    min_gap = 1000;
    wait_lock(400, "offset3_lock");
    checks++;
    if (pulses - p0 !== 5 || slip_cnt !== 4'd5) begin
      errors++;
      $display("FAIL offset3_slips: pulses=%0d slip_cnt=%0d, required 5 and 5", pulses - p0, slip_cnt);
    end
    checks++;
    if (min_gap < 17) begin
      errors++;
      $display("FAIL offset3_gap: min pulse gap=%0d, required >= 17", min_gap);
    end
    checks++;
    if (fail !== 1'b0) begin
      errors++;
      $display("FAIL offset3_fail: fail=%b, required 0", fail);
    end
  endtask

  task automatic test_stuck();
    int p0, n = 0;
    bad_en = 1'b1;
    bad_word = 8'hAA;
    restart(0);
    p0 = pulses;
    while (!fail && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (fail !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL stuck_fail: fail=%b locked=%b, required 1 and 0", fail, locked);
    end
    checks++;
    if (pulses - p0 !== 7) begin
      errors++;
      $display("FAIL stuck_pulses: pulses=%0d, required 7", pulses - p0);
    end
    p0 = pulses;
    repeat (30) tick();
    checks++;
    if (pulses !== p0 || fail !== 1'b1) begin
      errors++;
      $display("FAIL stuck_hold: extra pulses=%0d fail=%b, required 0 and 1", pulses - p0, fail);
    end
    bad_en = 1'b0;
    set_rotation(0);
    realign = 1'b1;
    tick();
    realign = 1'b0;
    checks++;
    if (fail !== 1'b0 || slip_cnt !== 4'd0 || dut.state !== S_SETTLE) begin
      errors++;
      $display("FAIL stuck_realign: fail=%b slip_cnt=%0d state=%0d, required 0, 0, %0d",
               fail, slip_cnt, dut.state, S_SETTLE);
    end
    wait_lock(200, "stuck_relock");
  endtask

  task automatic test_errors();
    int p0;
    bad_en = 1'b1;
    bad_word = 8'h00;
    drive();
    repeat (3) tick();
    bad_en = 1'b0;
    drive();
    repeat (2) tick();
    checks++;
    if (locked !== 1'b1 || frame_err_cnt !== 16'd3) begin
      errors++;
      $display("FAIL err_three: locked=%b frame_err_cnt=%0d, required 1 and 3", locked, frame_err_cnt);
    end
    p0 = pulses;
    bad_en = 1'b1;
    drive();
    repeat (4) tick();
    bad_en = 1'b0;
    set_rotation(1);
    repeat (2) tick();
    checks++;
    if (locked !== 1'b0 || frame_err_cnt !== 16'd7) begin
      errors++;
      $display("FAIL err_four: locked=%b frame_err_cnt=%0d, required 0 and 7", locked, frame_err_cnt);
    end
    wait_lock(400, "err_relock");
    checks++;
    if (pulses - p0 !== 7 || slip_cnt !== 4'd7 || fail !== 1'b0) begin
      errors++;
      $display("FAIL err_slips: pulses=%0d slip_cnt=%0d fail=%b, required 7, 7, 0",
               pulses - p0, slip_cnt, fail);
    end
  endtask

  task automatic test_realign_disable();
    int p0, n = 0;
    restart(4);
    p0 = pulses;
    while (!bitslip && n < 100) begin
      tick();
      n++;
    end
    realign = 1'b1;
    tick();
    realign = 1'b0;
    checks++;
    if (dut.state !== S_SETTLE || slip_cnt !== 4'd0 || bitslip !== 1'b0) begin
      errors++;
      $display("FAIL slip_realign: state=%0d slip_cnt=%0d bitslip=%b, required %0d, 0, 0",
               dut.state, slip_cnt, bitslip, S_SETTLE);
    end
    wait_lock(400, "slip_realign_lock");
    checks++;
    if (slip_cnt !== 4'd3 || pulses - p0 !== 4) begin
      errors++;
      $display("FAIL slip_realign_cnt: slip_cnt=%0d pulses=%0d, required 3 and 4", slip_cnt, pulses - p0);
    end
    enable = 1'b0;
    set_rotation(2);
    tick();
    checks++;
    if (locked !== 1'b0 || dut.state !== S_IDLE || slip_cnt !== 4'd3) begin
      errors++;
      $display("FAIL disable: locked=%b state=%0d slip_cnt=%0d, required 0, %0d, 3",
               locked, dut.state, slip_cnt, S_IDLE);
    end
    p0 = pulses;
    repeat (40) tick();
    checks++;
    if (pulses !== p0 || frame_err_cnt !== 16'd7) begin
      errors++;
      $display("FAIL disable_quiet: pulses=%0d frame_err_cnt=%0d, required 0 and 7", pulses - p0, frame_err_cnt);
    end
    enable = 1'b1;
    wait_lock(400, "reenable_lock");
    checks++;
    if (slip_cnt !== 4'd6) begin
      errors++;
      $display("FAIL reenable_slips: slip_cnt=%0d, required 6", slip_cnt);
    end
  endtask

  task automatic test_reset_mid();
    restart(0);
    repeat (5) tick();
    checks++;
    if (dut.state !== S_SETTLE) begin
      errors++;
      $display("FAIL midreset_pre: state=%0d, required %0d", dut.state, S_SETTLE);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({bitslip, locked, fail, slip_cnt, frame_err_cnt} !== 23'd0 || dut.state !== S_IDLE) begin
      errors++;
      $display("FAIL midreset: bs=%b lk=%b f=%b slip=%0d err=%0d state=%0d, required all 0 and IDLE",
               bitslip, locked, fail, slip_cnt, frame_err_cnt, dut.state);
    end
    reset = 1'b0;
    enable = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_offset3();
    test_stuck();
    test_errors();
    test_realign_disable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
